// File: rtl/mpc_types.sv
// Shared types for the hit-test pipeline's upstream bank-request path:
// request payload, configuration record and arbiter channel encodings.
package mpc_types;

  localparam int MPC_ARB_NUM_REQ = 3;

  typedef logic [1:0] arb_idx_t;

  localparam logic [MPC_ARB_NUM_REQ-1:0] MPC_CH0_1HOT = 3'b001;
  localparam logic [MPC_ARB_NUM_REQ-1:0] MPC_CH1_1HOT = 3'b010;
  localparam logic [MPC_ARB_NUM_REQ-1:0] MPC_CH2_1HOT = 3'b100;

  typedef struct packed {
    logic [3:0] num_banks;
    logic       age_en;
  } mpc_cfg_t;

  typedef struct packed {
    logic [27:0]                addr;
    logic [7:0]                 tag;
    logic [MPC_ARB_NUM_REQ-1:0] channel_1hot_id;
  } bank_req_t;

  // Round-robin successor: 0 -> 1 -> 2 -> 0.
  function automatic arb_idx_t arb_next_idx(arb_idx_t idx);
    case (idx)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [MPC_ARB_NUM_REQ-1:0] arb_idx_to_1hot(arb_idx_t idx);
    case (idx)
      2'd0:    return MPC_CH0_1HOT;
      2'd1:    return MPC_CH1_1HOT;
      default: return MPC_CH2_1HOT;
    endcase
  endfunction

endpackage

// File: rtl/mpc_bank_req_arb_if.sv
// Bank-request bus between the three requesters, the arbiter and the hit-test pipe.
// master = requester/downstream side, slave = arbiter side.
interface mpc_bank_req_arb_if #(
  parameter int NumReq = 3
);
  import mpc_types::*;

  logic [NumReq-1:0]     u_req_valid;
  logic [NumReq-1:0]     u_req_ready;
  bank_req_t [NumReq-1:0] u_req;
  logic                  d_bank_req_valid;
  logic                  d_bank_req_ready;
  bank_req_t             d_bank_req;
  arb_idx_t              d_grant_idx;

  modport master (
    output u_req_valid, u_req, d_bank_req_ready,
    input  u_req_ready, d_bank_req_valid, d_bank_req, d_grant_idx
  );

  modport slave (
    input  u_req_valid, u_req, d_bank_req_ready,
    output u_req_ready, d_bank_req_valid, d_bank_req, d_grant_idx
  );

endinterface

// File: rtl/mpc_rr_pick.sv
// Combinational rotate-priority picker for three requesters; any forced
// (aged-out) requester overrides the rotation, lowest index first.
module mpc_rr_pick
  import mpc_types::*;
(
  input  logic [MPC_ARB_NUM_REQ-1:0] req_i,
  input  arb_idx_t                   ptr_i,
  input  logic [MPC_ARB_NUM_REQ-1:0] force_i,
  output logic [MPC_ARB_NUM_REQ-1:0] gnt_o,
  output arb_idx_t                   idx_o
);

  arb_idx_t cand [MPC_ARB_NUM_REQ];

  assign cand[0] = ptr_i;
  assign cand[1] = arb_next_idx(ptr_i);
  assign cand[2] = arb_next_idx(cand[1]);

  // Loops run from lowest priority to highest so the last hit is the winner.
  always_comb begin
    idx_o = '0;
    gnt_o = '0;
    if (|(force_i & req_i)) begin
      for (int k = MPC_ARB_NUM_REQ - 1; k >= 0; k--) begin
        if (force_i[k] & req_i[k]) begin
          idx_o = arb_idx_t'(k);
        end
      end
    end else begin
      for (int k = MPC_ARB_NUM_REQ - 1; k >= 0; k--) begin
        if (req_i[cand[k]]) begin
          idx_o = cand[k];
        end
      end
    end
    if (|req_i) begin
      gnt_o = arb_idx_to_1hot(idx_o);
    end
  end

endmodule

// File: rtl/ns_gnrl_dfflr.sv
// Generic load-enable flop with asynchronous active-low reset to zero.
module ns_gnrl_dfflr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  logic [DW-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (lden) begin
      q_q <= dnxt;
    end
  end

  assign qout = q_q;

endmodule

// File: rtl/mpc_bank_req_arb.sv
// Round-robin arbiter sharing the single upstream bank-request port among three
// channels through a one-entry output register. Optional aging: MPC_ARB_AGE_EN.
module mpc_bank_req_arb
  import mpc_types::*;
#(
  parameter mpc_cfg_t Cfg      = '0,
  parameter int       NumReq   = 3,
  parameter int       AgeWidth = 4,
  parameter int       AgeMax   = 15
) (
  input logic               clk,
  input logic               rst_n,
  mpc_bank_req_arb_if.slave bus
);

  if (NumReq != MPC_ARB_NUM_REQ || AgeMax > (2 ** AgeWidth) - 1 || $bits(Cfg) == 0) begin : g_bad_cfg
    $error("mpc_bank_req_arb: unsupported NumReq/AgeWidth/AgeMax combination");
  end

  logic [NumReq-1:0] req_vld;
  logic [NumReq-1:0] gnt;
  logic [NumReq-1:0] force_vec;
  logic              slot_free;
  logic              hs;
  arb_idx_t          pick_idx;
  arb_idx_t          ptr_q;
  arb_idx_t          ptr_d;
  arb_idx_t          idx_q;
  logic              vld_q;
  logic              vld_d;
  logic              vld_en;
  bank_req_t         slot_q;
  bank_req_t         slot_d;

  assign req_vld   = bus.u_req_valid;
  assign slot_free = ~vld_q | bus.d_bank_req_ready;
  // Ready is held low during reset even though the empty slot looks free.
  assign hs        = rst_n & slot_free & (|gnt);

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_ready
    assign bus.u_req_ready[gi] = gnt[gi] & slot_free & rst_n;
  end

  mpc_rr_pick u_pick (
    .req_i   (req_vld),
    .ptr_i   (ptr_q),
    .force_i (force_vec),
    .gnt_o   (gnt),
    .idx_o   (pick_idx)
  );

  always_comb begin
    slot_d                 = bus.u_req[pick_idx];
    slot_d.channel_1hot_id = arb_idx_to_1hot(pick_idx);
    ptr_d                  = arb_next_idx(pick_idx);
    vld_d                  = hs;
    vld_en                 = hs | bus.d_bank_req_ready;
  end

  ns_gnrl_dfflr #(.DW(1)) u_vld_dff (
    .clk (clk), .rst_n (rst_n), .lden (vld_en), .dnxt (vld_d), .qout (vld_q)
  );

  ns_gnrl_dfflr #(.DW($bits(bank_req_t))) u_slot_dff (
    .clk (clk), .rst_n (rst_n), .lden (hs), .dnxt (slot_d), .qout (slot_q)
  );

  ns_gnrl_dfflr #(.DW($bits(arb_idx_t))) u_idx_dff (
    .clk (clk), .rst_n (rst_n), .lden (hs), .dnxt (pick_idx), .qout (idx_q)
  );

  ns_gnrl_dfflr #(.DW($bits(arb_idx_t))) u_ptr_dff (
    .clk (clk), .rst_n (rst_n), .lden (hs), .dnxt (ptr_d), .qout (ptr_q)
  );

`ifdef MPC_ARB_AGE_EN
  logic [NumReq-1:0][AgeWidth-1:0] age_q;
  logic [NumReq-1:0][AgeWidth-1:0] age_d;

  // A waiting channel counts up to AgeMax and sticks there until served.
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_age
    assign age_d[gi] = (!req_vld[gi] || bus.u_req_ready[gi]) ? '0 :
                       (age_q[gi] == AgeWidth'(AgeMax))      ? age_q[gi] :
                                                               age_q[gi] + AgeWidth'(1);
    assign force_vec[gi] = req_vld[gi] & (age_q[gi] == AgeWidth'(AgeMax));
  end

  ns_gnrl_dfflr #(.DW(NumReq * AgeWidth)) u_age_dff (
    .clk (clk), .rst_n (rst_n), .lden (1'b1), .dnxt (age_d), .qout (age_q)
  );
`else
  assign force_vec = '0;
`endif

  assign bus.d_bank_req_valid = vld_q;
  assign bus.d_bank_req       = slot_q;
  assign bus.d_grant_idx      = idx_q;

endmodule

// File: tb/tb_mpc_bank_req_arb.sv
// Self-checking bench for mpc_bank_req_arb: directed vector table, hand-written
// reset/backpressure sequences and randomized traffic against a reference model.
module tb_mpc_bank_req_arb;
  import mpc_types::*;

  localparam int AGE_MAX = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mpc_bank_req_arb_if #(.NumReq(3)) bus ();

  mpc_bank_req_arb #(
    .Cfg      ('0),
    .NumReq   (3),
    .AgeWidth (4),
    .AgeMax   (AGE_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] vld;
    logic       drdy;
    logic [2:0] exp_rdy;
    logic       exp_dvld;
    logic [2:0] exp_1hot;
    logic [1:0] exp_idx;
  } vec_t;

  vec_t vecs [17];

  // Reference model state
  bit        m_vld;
  bank_req_t m_pay;
  int        m_idx;
  int        m_ptr;
  int        m_age [3];
  bit        cur_v [3];
  bank_req_t cur   [3];

  task automatic drive(input logic [2:0] v, input logic dr);
    bus.u_req_valid      = v;
    bus.d_bank_req_ready = dr;
    for (int i = 0; i < 3; i++) bus.u_req[i] = cur[i];
  endtask

  task automatic model_reset();
    m_vld = 1'b0;
    m_pay = '0;
    m_idx = 0;
    m_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      m_age[i] = 0;
      cur_v[i] = 1'b0;
    end
  endtask

  // One cycle of random traffic; pattern mode: ch2 always requesting,
  // ch0/ch1 alternate when idle, downstream ready toggles 1,0.
  task automatic rand_cycle(input int cyc, input bit pattern);
    logic [2:0] v;
    logic       dr;
    logic [2:0] exp_rdy;
    int         w;
    bit         free;
    for (int i = 0; i < 3; i++) begin
      if (!cur_v[i]) begin
        if (pattern) cur_v[i] = (i == 2) || (i == (cyc % 2));
        else         cur_v[i] = ($urandom_range(0, 99) < 60);
        cur[i].addr            = 28'($urandom);
        cur[i].tag             = 8'($urandom);
        cur[i].channel_1hot_id = 3'($urandom);
      end
      v[i] = cur_v[i];
    end
    dr = pattern ? logic'(cyc % 2 == 0) : logic'($urandom_range(0, 3) != 0);
    drive(v, dr);

    w = -1;
`ifdef MPC_ARB_AGE_EN
    for (int i = 0; i < 3; i++)
      if (w < 0 && cur_v[i] && m_age[i] == AGE_MAX) w = i;
`endif
    for (int k = 0; k < 3; k++)
      if (w < 0 && cur_v[(m_ptr + k) % 3]) w = (m_ptr + k) % 3;
    free    = !m_vld || dr;
    exp_rdy = (free && w >= 0) ? 3'(1 << w) : 3'b000;
    #1;
    check($sformatf("rand_rdy c%0d", cyc), 64'(bus.u_req_ready), 64'(exp_rdy));

    @(posedge clk);
`ifdef MPC_ARB_AGE_EN
    for (int i = 0; i < 3; i++) begin
      if (!cur_v[i] || exp_rdy[i]) m_age[i] = 0;
      else if (m_age[i] < AGE_MAX) m_age[i]++;
    end
`endif
    if (exp_rdy != 3'b000) begin
      m_vld                 = 1'b1;
      m_pay                 = cur[w];
      m_pay.channel_1hot_id = 3'(1 << w);
      m_idx                 = w;
      m_ptr                 = (w + 1) % 3;
      cur_v[w]              = 1'b0;
    end else if (dr) begin
      m_vld = 1'b0;
    end

    @(negedge clk);
    check($sformatf("rand_dvld c%0d", cyc), 64'(bus.d_bank_req_valid), 64'(m_vld));
    if (m_vld) begin
      check($sformatf("rand_pay c%0d", cyc), 64'(bus.d_bank_req), 64'(m_pay));
      check($sformatf("rand_idx c%0d", cyc), 64'(bus.d_grant_idx), 64'(m_idx));
    end
  endtask

  initial begin
    // Directed table, starting right after reset release (ptr=0, slot empty).
    vecs[0] = '{3'b111, 1'b1, 3'b001, 1'b1, 3'b001, 2'd0};
    vecs[1] = '{3'b111, 1'b1, 3'b010, 1'b1, 3'b010, 2'd1};
    vecs[2] = '{3'b111, 1'b1, 3'b100, 1'b1, 3'b100, 2'd2};
    vecs[3] = '{3'b111, 1'b1, 3'b001, 1'b1, 3'b001, 2'd0};
    for (int r = 4; r < 8; r++) vecs[r] = '{3'b100, 1'b1, 3'b100, 1'b1, 3'b100, 2'd2};
    vecs[8] = '{3'b011, 1'b1, 3'b001, 1'b1, 3'b001, 2'd0};
    for (int r = 9; r < 14; r++) vecs[r] = '{3'b011, 1'b0, 3'b000, 1'b1, 3'b001, 2'd0};
`ifdef MPC_ARB_AGE_EN
    vecs[14] = '{3'b011, 1'b1, 3'b001, 1'b1, 3'b001, 2'd0};
`else
    vecs[14] = '{3'b011, 1'b1, 3'b010, 1'b1, 3'b010, 2'd1};
`endif
    vecs[15] = '{3'b000, 1'b1, 3'b000, 1'b0, 3'b000, 2'd0};
    vecs[16] = '{3'b001, 1'b1, 3'b001, 1'b1, 3'b001, 2'd0};

    for (int i = 0; i < 3; i++) begin
      cur[i].addr            = 28'(32'h100 * (i + 1) + 5);
      cur[i].tag             = 8'(i + 8'h40);
      cur[i].channel_1hot_id = 3'b111;
    end

    // Reset state, with requests already pending.
    rst_n = 1'b0;
    drive(3'b111, 1'b1);
    repeat (2) @(negedge clk);
    check("reset_dvld", 64'(bus.d_bank_req_valid), 64'd0);
    check("reset_dreq", 64'(bus.d_bank_req), 64'd0);
    check("reset_idx", 64'(bus.d_grant_idx), 64'd0);
    check("reset_rdy", 64'(bus.u_req_ready), 64'd0);
    rst_n = 1'b1;

    for (int r = 0; r < 17; r++) begin
      drive(vecs[r].vld, vecs[r].drdy);
      #1;
      check($sformatf("vec%0d_rdy", r), 64'(bus.u_req_ready), 64'(vecs[r].exp_rdy));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_dvld", r), 64'(bus.d_bank_req_valid), 64'(vecs[r].exp_dvld));
      if (vecs[r].exp_dvld) begin
        check($sformatf("vec%0d_1hot", r), 64'(bus.d_bank_req.channel_1hot_id), 64'(vecs[r].exp_1hot));
        check($sformatf("vec%0d_idx", r), 64'(bus.d_grant_idx), 64'(vecs[r].exp_idx));
      end
    end
    // Payload of the last load must be channel 0's with the id replaced.
    check("vec_addr", 64'(bus.d_bank_req.addr), 64'(cur[0].addr));

    // Load a channel-1 request, hold it, then reset asynchronously mid-cycle.
    drive(3'b010, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(3'b111, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("hold_1hot", 64'(bus.d_bank_req.channel_1hot_id), 64'(3'b010));
    check("hold_rdy", 64'(bus.u_req_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_dvld", 64'(bus.d_bank_req_valid), 64'd0);
    check("async_rdy", 64'(bus.u_req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b111, 1'b1);
    #1;
    check("post_rst_rdy", 64'(bus.u_req_ready), 64'(3'b001));
    @(posedge clk);
    @(negedge clk);
    check("post_rst_1hot", 64'(bus.d_bank_req.channel_1hot_id), 64'(3'b001));

    // Randomized traffic from a fresh reset.
    rst_n = 1'b0;
    model_reset();
    drive(3'b000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) rand_cycle(c, 1'b0);

    rst_n = 1'b0;
    model_reset();
    drive(3'b000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 60; c++) rand_cycle(c, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
